// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the data-memory responder.
package data_mem_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2,
        ST_DUMP = 2'd3
    } state_t;

    // Byte address to word index; callers keep only the low index bits (wrap).
    function automatic logic [15:0] byte_to_word(input logic [15:0] byte_addr);
        return byte_addr >> 4'd1;
    endfunction

endpackage

// File: rtl/data_mem_array.sv
// Single-port word array with registered read and no reset.
module data_mem_array
    import data_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int IDX_W       = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [IDX_W-1:0]  addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem_r [DEPTH_WORDS];

    // Storage write and registered read share the single address port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem_r[addr];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency, stall-generating data-memory responder with a debug dump walk.
// Define DATA_MEM_ALIGN_CHECK_EN to flag odd byte addresses with err.
module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              wr,
    input  logic [15:0]       addr,
    input  logic [WORD_W-1:0] data_in,
    input  logic              createdump,
    output logic [WORD_W-1:0] data_out,
    output logic              done,
    output logic              stall,
    output logic              err,
    output logic              dump_valid,
    output logic [15:0]       dump_addr,
    output logic [WORD_W-1:0] dump_data
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH_WORDS - 1);

    state_t              state_r;
    logic [CNT_W-1:0]    cnt_r;
    logic                wr_r;
    logic [IDX_W-1:0]    idx_r;
    logic [WORD_W-1:0]   wdata_r;
    logic                mis_r;
    logic                done_r;
    logic                err_r;
    logic                rd_sel_r;
    logic                dump_valid_r;
    logic [15:0]         dump_addr_r;
    logic [IDX_W-1:0]    dump_idx_r;

    logic [15:0]         word_full_s;
    logic [IDX_W-1:0]    req_idx_s;
    logic                mis_s;
    logic                accept_s;
    logic                dump_start_s;
    logic                dump_step_s;
    logic [IDX_W-1:0]    dump_next_s;
    logic                commit_s;
    logic                c_wr_s;
    logic [IDX_W-1:0]    c_idx_s;
    logic [WORD_W-1:0]   c_wdata_s;
    logic                c_mis_s;
    logic                mem_we_s;
    logic                mem_re_s;
    logic [IDX_W-1:0]    mem_addr_s;
    logic [WORD_W-1:0]   mem_rdata_s;
    logic                unused_bits_s;

    assign word_full_s   = byte_to_word(addr);
    assign req_idx_s     = word_full_s[IDX_W-1:0];
    assign unused_bits_s = ^{word_full_s[15:IDX_W], addr[0]};

`ifdef DATA_MEM_ALIGN_CHECK_EN
    assign mis_s = addr[0];
`else
    assign mis_s = 1'b0;
`endif

    assign accept_s     = enable && ((state_r == ST_IDLE) || (state_r == ST_RESP));
    assign dump_start_s = !enable && createdump && ((state_r == ST_IDLE) || (state_r == ST_RESP));
    assign dump_step_s  = (state_r == ST_DUMP) && (dump_idx_r != LAST_IDX);
    assign dump_next_s  = dump_idx_r + IDX_W'(1);

    // Select the request that completes this cycle; single-cycle latency completes on acceptance.
    always_comb begin
        if (LATENCY == 32'sd1) begin
            commit_s  = accept_s;
            c_wr_s    = wr;
            c_idx_s   = req_idx_s;
            c_wdata_s = data_in;
            c_mis_s   = mis_s;
        end else begin
            commit_s  = (state_r == ST_BUSY) && (cnt_r == CNT_W'(1));
            c_wr_s    = wr_r;
            c_idx_s   = idx_r;
            c_wdata_s = wdata_r;
            c_mis_s   = mis_r;
        end
    end

    // Arbitrate the single array port between request completion and the dump walk.
    always_comb begin
        mem_we_s   = commit_s && c_wr_s && !c_mis_s;
        mem_re_s   = 1'b0;
        mem_addr_s = idx_r;
        if (commit_s) begin
            mem_re_s   = !c_wr_s && !c_mis_s;
            mem_addr_s = c_idx_s;
        end else if (dump_start_s) begin
            mem_re_s   = 1'b1;
            mem_addr_s = '0;
        end else if (dump_step_s) begin
            mem_re_s   = 1'b1;
            mem_addr_s = dump_next_s;
        end else begin
            mem_re_s   = 1'b0;
            mem_addr_s = idx_r;
        end
    end

    data_mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (mem_we_s),
        .re    (mem_re_s),
        .addr  (mem_addr_s),
        .wdata (c_wdata_s),
        .rdata (mem_rdata_s)
    );

    // Request/dump state machine with registered response flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            cnt_r        <= '0;
            wr_r         <= 1'b0;
            idx_r        <= '0;
            wdata_r      <= '0;
            mis_r        <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
            rd_sel_r     <= 1'b0;
            dump_valid_r <= 1'b0;
            dump_addr_r  <= 16'h0000;
            dump_idx_r   <= '0;
        end else begin
            done_r       <= commit_s;
            err_r        <= commit_s && c_mis_s;
            rd_sel_r     <= commit_s && !c_wr_s && !c_mis_s;
            dump_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE, ST_RESP: begin
                    if (accept_s) begin
                        wr_r    <= wr;
                        idx_r   <= req_idx_s;
                        wdata_r <= data_in;
                        mis_r   <= mis_s;
                        cnt_r   <= LAT_LOAD;
                        state_r <= (LATENCY == 32'sd1) ? ST_RESP : ST_BUSY;
                    end else if (createdump) begin
                        state_r      <= ST_DUMP;
                        dump_idx_r   <= '0;
                        dump_addr_r  <= 16'h0000;
                        dump_valid_r <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    cnt_r <= cnt_r - CNT_W'(1);
                    if (cnt_r == CNT_W'(1)) begin
                        state_r <= ST_RESP;
                    end else begin
                        state_r <= ST_BUSY;
                    end
                end
                ST_DUMP: begin
                    if (dump_idx_r == LAST_IDX) begin
                        state_r     <= ST_IDLE;
                        dump_addr_r <= 16'h0000;
                    end else begin
                        dump_idx_r   <= dump_next_s;
                        dump_addr_r  <= 16'({dump_next_s, 1'b0});
                        dump_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign stall      = (state_r == ST_BUSY) || (state_r == ST_DUMP);
    assign done       = done_r;
    assign err        = err_r;
    assign data_out   = rd_sel_r ? mem_rdata_s : 16'h0000;
    assign dump_valid = dump_valid_r;
    assign dump_addr  = dump_addr_r;
    assign dump_data  = dump_valid_r ? mem_rdata_s : 16'h0000;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: vector table, scoreboard and corner sequences.
module tb_data_mem_responder;

    localparam int DEPTH = 256;
    localparam int LAT   = 2;
    localparam int IDX_W = 8;

`ifdef DATA_MEM_ALIGN_CHECK_EN
    localparam bit ALN = 1'b1;
`else
    localparam bit ALN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        enable;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic        createdump;
    logic [15:0] data_out;
    logic        done;
    logic        stall;
    logic        err;
    logic        dump_valid;
    logic [15:0] dump_addr;
    logic [15:0] dump_data;

    data_mem_responder #(
        .DEPTH_WORDS (DEPTH),
        .LATENCY     (LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .wr         (wr),
        .addr       (addr),
        .data_in    (data_in),
        .createdump (createdump),
        .data_out   (data_out),
        .done       (done),
        .stall      (stall),
        .err        (err),
        .dump_valid (dump_valid),
        .dump_addr  (dump_addr),
        .dump_data  (dump_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] dout;
        logic        err;
        int          done_cyc;
        int          tag;
    } exp_t;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] din;
        logic [15:0] exp_dout;
        logic        exp_err;
    } vec_t;

    exp_t        sb[$];
    vec_t        vec[12];
    logic [15:0] mem_m [DEPTH];
    int          pass_cnt = 0;
    int          total_cnt = 0;
    int          cyc_n = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total_cnt++;
        if (act !== req) begin
            $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, req, cyc_n);
        end else begin
            pass_cnt++;
        end
    endfunction

    // One cycle: advance to the falling edge and score any response due now.
    task automatic tick();
        exp_t e;
        logic exp_done;
        @(negedge clk);
        cyc_n++;
        exp_done = (sb.size() > 0) && (sb[0].done_cyc == cyc_n);
        chk("done", 32'(done), 32'(exp_done));
        if (exp_done) begin
            e = sb.pop_front();
            chk($sformatf("data_out[tag %0d]", e.tag), 32'(data_out), 32'(e.dout));
            chk($sformatf("err[tag %0d]", e.tag), 32'(err), 32'(e.err));
        end
    endtask

    task automatic send(input logic w, input logic [15:0] a, input logic [15:0] d,
                        input logic [15:0] edout, input logic eerr, input int tag);
        exp_t e;
        enable  = 1'b1;
        wr      = w;
        addr    = a;
        data_in = d;
        e.dout     = edout;
        e.err      = eerr;
        e.done_cyc = cyc_n + LAT;
        e.tag      = tag;
        sb.push_back(e);
        if (w && !eerr) mem_m[a[IDX_W:1]] = d;
        tick();
        enable = 1'b0;
        wr     = 1'b0;
    endtask

    task automatic ready();
        int n;
        n = 0;
        while (stall && n < 400) begin
            tick();
            n++;
        end
        chk("ready_timeout", 32'(stall), 32'(0));
    endtask

    initial begin
        rst        = 1'b0;
        enable     = 1'b0;
        wr         = 1'b0;
        addr       = 16'h0000;
        data_in    = 16'h0000;
        createdump = 1'b0;

        vec[0]  = '{1'b1, 16'h0010, 16'hBEEF, 16'h0000, 1'b0};
        vec[1]  = '{1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0};
        vec[2]  = '{1'b1, 16'h0204, 16'h1234, 16'h0000, 1'b0};
        vec[3]  = '{1'b0, 16'h0004, 16'h0000, 16'h1234, 1'b0};
        vec[4]  = '{1'b0, 16'h0006, 16'h0000, 16'hA503, 1'b0};
        vec[5]  = '{1'b0, 16'hFFFE, 16'h0000, 16'hA5FF, 1'b0};
        vec[6]  = '{1'b1, 16'h01FE, 16'h0000, 16'h0000, 1'b0};
        vec[7]  = '{1'b0, 16'hFFFE, 16'h0000, 16'h0000, 1'b0};
        vec[8]  = '{1'b0, 16'h00FE, 16'h0000, 16'hA57F, 1'b0};
        vec[9]  = '{1'b1, 16'h0011, 16'h5A5A, 16'h0000, ALN};
        vec[10] = '{1'b0, 16'h0010, 16'h0000, (ALN ? 16'hBEEF : 16'h5A5A), 1'b0};
        vec[11] = '{1'b0, 16'h0011, 16'h0000, (ALN ? 16'h0000 : 16'h5A5A), ALN};

        // Reset state.
        tick();
        tick();
        chk("rst_stall", 32'(stall), 32'(0));
        chk("rst_data_out", 32'(data_out), 32'(0));
        chk("rst_err", 32'(err), 32'(0));
        chk("rst_dump_valid", 32'(dump_valid), 32'(0));
        chk("rst_dump_addr", 32'(dump_addr), 32'(0));
        chk("rst_dump_data", 32'(dump_data), 32'(0));
        rst = 1'b1;
        tick();

        // Preload every word back-to-back so the dump has known contents.
        for (int i = 0; i < DEPTH; i++) begin
            send(1'b1, 16'(i * 2), 16'hA500 | 16'(i), 16'h0000, 1'b0, 1000 + i);
            ready();
        end

        // Latency and stall from IDLE.
        tick();
        tick();
        send(1'b1, 16'h0030, 16'h7777, 16'h0000, 1'b0, 500);
        chk("busy_stall", 32'(stall), 32'(1));
        tick();
        chk("resp_stall", 32'(stall), 32'(0));
        send(1'b0, 16'h0030, 16'h0000, 16'h7777, 1'b0, 501);
        ready();

        // Vector table, mixing idle gaps with back-to-back acceptance.
        for (int i = 0; i < 12; i++) begin
            if (i % 3 == 0) begin
                tick();
                tick();
            end
            send(vec[i].wr, vec[i].addr, vec[i].din, vec[i].exp_dout, vec[i].exp_err, i);
            ready();
        end

        // enable wins over createdump.
        tick();
        tick();
        createdump = 1'b1;
        send(1'b0, 16'h0006, 16'h0000, 16'hA503, 1'b0, 600);
        createdump = 1'b0;
        chk("prio_no_dump", 32'(dump_valid), 32'(0));
        ready();

        // Reset during BUSY of a write drops the write.
        tick();
        tick();
        enable  = 1'b1;
        wr      = 1'b1;
        addr    = 16'h0020;
        data_in = 16'hDEAD;
        tick();
        enable = 1'b0;
        wr     = 1'b0;
        chk("pre_rst_busy", 32'(stall), 32'(1));
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_stall", 32'(stall), 32'(0));
        chk("mid_rst_done", 32'(done), 32'(0));
        chk("mid_rst_data_out", 32'(data_out), 32'(0));
        chk("mid_rst_dump_valid", 32'(dump_valid), 32'(0));
        tick();
        tick();
        rst = 1'b1;
        tick();
        send(1'b0, 16'h0020, 16'h0000, 16'hA510, 1'b0, 700);
        ready();

        // Dump walk from IDLE.
        tick();
        tick();
        createdump = 1'b1;
        tick();
        createdump = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            chk($sformatf("dump_valid[%0d]", i), 32'(dump_valid), 32'(1));
            chk($sformatf("dump_addr[%0d]", i), 32'(dump_addr), 32'(i * 2));
            chk($sformatf("dump_data[%0d]", i), 32'(dump_data), 32'(mem_m[i]));
            chk($sformatf("dump_stall[%0d]", i), 32'(stall), 32'(1));
            tick();
        end
        chk("dump_end_valid", 32'(dump_valid), 32'(0));
        chk("dump_end_stall", 32'(stall), 32'(0));
        send(1'b0, 16'h0004, 16'h0000, 16'h1234, 1'b0, 800);
        ready();

        for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
        chk("sb_drain", 32'(sb.size()), 32'(0));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
